// File: rtl/hex_pkg.sv
// hex_pkg: shared segment types and decode constants for the 7-seg refresh controller.
package hex_pkg;
  typedef logic [6:0] seg_t;
  typedef enum logic {IDLE, SCAN} scan_state_t;
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b0000011;
  localparam seg_t SEG_C = 7'b1000110;
  localparam seg_t SEG_D = 7'b0100001;
  localparam seg_t SEG_E = 7'b0000110;
  localparam seg_t SEG_F = 7'b0001110;
  localparam seg_t SEG_LUT [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
endpackage

// File: rtl/hex_seg_decode.sv
// hex_seg_decode: combinational hex value + enable to active-low segment pattern.
module hex_seg_decode
  import hex_pkg::*;
(
  input  logic [3:0] val,
  input  logic       en,
  output seg_t       seg
);
  always_comb seg = en ? SEG_LUT[val] : SEG_BLANK;
endmodule

// File: rtl/hex_refresh_ctrl.sv
// hex_refresh_ctrl: per-digit value/enable register file scanned round-robin through one shared decoder.
module hex_refresh_ctrl
  import hex_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_WIDTH = 4,
  parameter int TICK_DIV   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [2:0]              wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_en,
  output logic                    wr_err,
  output logic [NUM_DIGITS*7-1:0] hex_out,
  output logic [2:0]              scan_idx,
  output logic                    frame_done
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  scan_state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] val [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] en;
  logic commit, xfer, in_range;
  seg_t seg;
  always_ff @(posedge clk) state <= reset ? IDLE : state_nxt;
  always_comb state_nxt = (state == IDLE) ? SCAN : state;
  always_comb begin
    commit     = (state == SCAN) && (cnt == CW'(TICK_DIV - 1));
    wr_ready   = (state == SCAN) && !commit;
    frame_done = commit && (scan_idx == 3'(NUM_DIGITS - 1));
    xfer       = wr_valid && wr_ready;
    in_range   = int'(wr_idx) < NUM_DIGITS;
  end
  hex_seg_decode u_dec (
    .val(val[scan_idx]),
    .en (en[scan_idx]),
    .seg(seg)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      scan_idx <= '0;
      wr_err   <= 1'b0;
      en       <= '0;
      hex_out  <= {NUM_DIGITS{SEG_BLANK}};
      for (int i = 0; i < NUM_DIGITS; i++) val[i] <= '0;
    end else begin
      wr_err <= xfer && !in_range;
      if (state == SCAN) cnt <= commit ? '0 : cnt + 1'b1;
      if (xfer && in_range) begin
        val[wr_idx] <= wr_data;
        en[wr_idx]  <= wr_en;
      end
      if (commit) begin
        hex_out[int'(scan_idx)*7 +: 7] <= seg;
        scan_idx <= (scan_idx == 3'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hex_refresh_ctrl.sv
// tb_hex_refresh_ctrl: directed checks of scan timing, handshake, decode and reset for hex_refresh_ctrl.
module tb_hex_refresh_ctrl;
  logic clk = 0, reset = 1, wr_valid = 0, wr_en = 0;
  logic [2:0] wr_idx = 0, scan_idx;
  logic [3:0] wr_data = 0;
  logic wr_ready, wr_err, frame_done;
  logic [41:0] hex_out;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  hex_refresh_ctrl #(.NUM_DIGITS(6), .DATA_WIDTH(4), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_data(wr_data), .wr_en(wr_en), .wr_err(wr_err), .hex_out(hex_out),
    .scan_idx(scan_idx), .frame_done(frame_done)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic wr(input logic [2:0] i, input logic [3:0] d, input logic e);
    bit acc = 0;
    wr_valid = 1; wr_idx = i; wr_data = d; wr_en = e;
    for (int t = 0; t < 10 && !acc; t++) begin
      acc = wr_ready;
      tick();
    end
    wr_valid = 0;
    if (!acc) chk("wr_timeout", 0, 1);
  endtask
  function automatic logic [6:0] dig(input int i);
    return hex_out[i*7 +: 7];
  endfunction
  initial begin
    repeat (3) tick();
    chk("rst_hex", hex_out, {6{7'h7F}});
    chk("rst_rdy", wr_ready, 0);
    chk("rst_idx", scan_idx, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_err", wr_err, 0);
    reset = 0;
    for (int k = 0; k < 50; k++) begin
      chk("scan_rdy", wr_ready, (k == 0) ? 0 : (((k - 1) % 4) != 3));
      chk("scan_idx", scan_idx, (k == 0) ? 0 : ((k - 1) / 4) % 6);
      chk("scan_fd", frame_done, (k > 0) && (((k - 1) % 24) == 23));
      chk("scan_hex", hex_out, {6{7'h7F}});
      tick();
    end
    wr(2, 5, 1);
    chk("wr_noerr", wr_err, 0);
    repeat (25) tick();
    chk("d2_five", dig(2), 7'b0010010);
    chk("others_blank", hex_out & ~(42'h7F << 14), {6{7'h7F}} & ~(42'h7F << 14));
    wr(0, 0, 0);
    repeat (25) tick();
    chk("d0_disabled", dig(0), 7'h7F);
    wr(0, 0, 1);
    repeat (25) tick();
    chk("d0_zero", dig(0), 7'b1000000);
    chk("d2_kept", dig(2), 7'b0010010);
    for (int t = 0; t < 10 && wr_ready; t++) tick();
    wr_valid = 1; wr_idx = 1; wr_data = 4'hF; wr_en = 1;
    chk("hold_rdy0", wr_ready, 0);
    tick();
    chk("hold_rdy1", wr_ready, 1);
    tick();
    wr_valid = 0;
    repeat (25) tick();
    chk("d1_held_f", dig(1), 7'b0001110);
    for (int i = 0; i < 6; i++) wr(3'(i), 4'hF, 1);
    repeat (25) tick();
    chk("all_f", hex_out, {6{7'b0001110}});
    wr(6, 0, 0);
    chk("err6_hi", wr_err, 1);
    tick();
    chk("err6_lo", wr_err, 0);
    wr(7, 3, 0);
    chk("err7_hi", wr_err, 1);
    tick();
    chk("err7_lo", wr_err, 0);
    repeat (25) tick();
    chk("err_nochange", hex_out, {6{7'b0001110}});
    for (int t = 0; t < 30 && scan_idx != 3; t++) tick();
    chk("mid_idx3", scan_idx, 3);
    reset = 1;
    tick();
    chk("mrst_hex", hex_out, {6{7'h7F}});
    chk("mrst_idx", scan_idx, 0);
    chk("mrst_rdy", wr_ready, 0);
    reset = 0;
    repeat (50) tick();
    chk("mrst_lost", hex_out, {6{7'h7F}});
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
